regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RISC-V core and its SQED verification harness. It provides NRD combinational read ports and NWR write ports, a hardwired-zero entry 0, and same-cycle write-to-read bypass. A sequenced initialisation engine loads every entry after reset, or on request, with either zero or its own index, so SQED original/duplicate register halves start in a known, distinguishable state.

---
 rtl/regfile_mp.sv | 143 ++++++++++++++
 tb/tb_regfile_mp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired-zero entry 0,
// same-cycle write-to-read bypass and a sequenced initialisation engine
// that loads every entry with zero or its own index after reset or on request.
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int AW        = $clog2(NREGS),
  parameter int NRD       = 2,
  parameter int NWR       = 2,
  parameter int INIT_MODE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_req,
  output logic                ready,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic                wr_conflict
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            wr_conflict_q, wr_conflict_d;
  logic            collide;
  logic [XLEN-1:0] init_val;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  assign ready       = ready_q;
  assign wr_conflict = wr_conflict_q;

  // Value loaded into the entry currently addressed by the init counter.
  always_comb begin
    init_val = '0;
    if (INIT_MODE == 1) init_val = XLEN'(cnt_q);
  end

  // Detect two or more enabled write ports aimed at the same nonzero entry.
  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (we[i] && we[j] && (waddr[i*AW +: AW] == waddr[j*AW +: AW]) &&
            (waddr[i*AW +: AW] != '0)) begin
          collide = 1'b1;
        end
      end
    end
  end

  // Control FSM: walk the init counter through every entry, then serve writes.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ready_d       = ready_q;
    wr_conflict_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        ready_d = 1'b0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_d       = 1'b1;
        wr_conflict_d = collide;
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Control registers; storage is deliberately left out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Next storage contents; ascending port order lets the highest port win.
  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_INIT) begin
      mem_d[cnt_q] = init_val;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] != '0)) begin
          mem_d[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Storage array update.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Combinational read ports with zero entry and highest-port write bypass.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NRD; k++) begin
      if ((state_q == ST_RUN) && (raddr[k*AW +: AW] != '0)) begin
        rdata[k*XLEN +: XLEN] = mem_q[raddr[k*AW +: AW]];
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (waddr[j*AW +: AW] == raddr[k*AW +: AW])) begin
            rdata[k*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default configuration (INIT_MODE=1, NREGS=32, NRD=2, NWR=2)
  logic        init_m;
  logic        ready_m, conf_m;
  logic [1:0]  we_m;
  logic [9:0]  waddr_m;
  logic [63:0] wdata_m;
  logic [9:0]  raddr_m;
  logic [63:0] rdata_m;

  // Zero-initialised configuration
  logic        init_z;
  logic        ready_z, conf_z;
  logic [1:0]  we_z;
  logic [9:0]  waddr_z;
  logic [63:0] wdata_z;
  logic [9:0]  raddr_z;
  logic [63:0] rdata_z;

  // Small configuration (NREGS=16, NRD=3, NWR=1)
  logic        init_s;
  logic        ready_s, conf_s;
  logic [0:0]  we_s;
  logic [3:0]  waddr_s;
  logic [31:0] wdata_s;
  logic [11:0] raddr_s;
  logic [95:0] rdata_s;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp dut_m (
    .clk(clk), .rst_n(rst_n), .init_req(init_m), .ready(ready_m),
    .we(we_m), .waddr(waddr_m), .wdata(wdata_m), .raddr(raddr_m),
    .rdata(rdata_m), .wr_conflict(conf_m)
  );

  regfile_mp #(.INIT_MODE(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .init_req(init_z), .ready(ready_z),
    .we(we_z), .waddr(waddr_z), .wdata(wdata_z), .raddr(raddr_z),
    .rdata(rdata_z), .wr_conflict(conf_z)
  );

  regfile_mp #(.NREGS(16), .NRD(3), .NWR(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .init_req(init_s), .ready(ready_s),
    .we(we_s), .waddr(waddr_s), .wdata(wdata_s), .raddr(raddr_s),
    .rdata(rdata_s), .wr_conflict(conf_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (ready_m !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_m); end
    n_checks++;
    if (conf_m !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b want 0", conf_m); end
    n_checks++;
    if (ready_s !== 1'b0) begin n_fail++; $display("FAIL reset_ready_small: got %b want 0", ready_s); end
  endtask

  // Release reset and walk the init sequence with writes and init_req applied.
  task automatic test_init_seq();
    bit early = 1'b0;
    we_m = 2'b01; waddr_m = {5'd0, 5'd4}; wdata_m = {32'h0, 32'h000000AB};
    raddr_m = {5'd0, 5'd5};
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      init_m = (i == 10);
      tick();
      if (i < 32 && ready_m) early = 1'b1;
      if (i == 1) begin
        n_checks++;
        if (rdata_m[31:0] !== 32'h0) begin n_fail++; $display("FAIL init_read_zero: got %h want 00000000", rdata_m[31:0]); end
      end
      if (i == 15) begin
        n_checks++;
        if (ready_s !== 1'b0) begin n_fail++; $display("FAIL small_ready_15: got %b want 0", ready_s); end
      end
      if (i == 16) begin
        n_checks++;
        if (ready_s !== 1'b1) begin n_fail++; $display("FAIL small_ready_16: got %b want 1", ready_s); end
      end
      if (i == 31) begin
        n_checks++;
        if (ready_m !== 1'b0) begin n_fail++; $display("FAIL ready_edge31: got %b want 0", ready_m); end
      end
      if (i == 32) begin
        n_checks++;
        if (ready_m !== 1'b1) begin n_fail++; $display("FAIL ready_edge32: got %b want 1", ready_m); end
        n_checks++;
        if (ready_z !== 1'b1) begin n_fail++; $display("FAIL ready_zero_edge32: got %b want 1", ready_z); end
      end
    end
    init_m = 1'b0;
    we_m   = 2'b00;
    n_checks++;
    if (early !== 1'b0) begin n_fail++; $display("FAIL ready_early: got %b want 0", early); end
    raddr_m = {5'd5, 5'd4};
    #1;
    n_checks++;
    if (rdata_m[31:0] !== 32'h4) begin n_fail++; $display("FAIL init_write_dropped_x4: got %h want 00000004", rdata_m[31:0]); end
    n_checks++;
    if (rdata_m[63:32] !== 32'h5) begin n_fail++; $display("FAIL init_x5: got %h want 00000005", rdata_m[63:32]); end
    raddr_m = {5'd0, 5'd31};
    #1;
    n_checks++;
    if (rdata_m[31:0] !== 32'h1F) begin n_fail++; $display("FAIL init_x31: got %h want 0000001f", rdata_m[31:0]); end
    raddr_z = {5'd31, 5'd5};
    #1;
    n_checks++;
    if (rdata_z !== 64'h0) begin n_fail++; $display("FAIL zero_mode_reads: got %h want 0", rdata_z); end
  endtask

  task automatic test_write_bypass();
    we_m = 2'b01; waddr_m = {5'd0, 5'd3}; wdata_m = {32'h0, 32'hDEADBEEF};
    raddr_m = {5'd3, 5'd3};
    #1;
    n_checks++;
    if (rdata_m[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_p0: got %h want deadbeef", rdata_m[31:0]); end
    n_checks++;
    if (rdata_m[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_p1: got %h want deadbeef", rdata_m[63:32]); end
    tick();
    we_m = 2'b00;
    #1;
    n_checks++;
    if (rdata_m[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_x3: got %h want deadbeef", rdata_m[31:0]); end
    n_checks++;
    if (conf_m !== 1'b0) begin n_fail++; $display("FAIL single_write_conflict: got %b want 0", conf_m); end
  endtask

  task automatic test_collision();
    we_m = 2'b11; waddr_m = {5'd7, 5'd7}; wdata_m = {32'h22, 32'h11};
    raddr_m = {5'd7, 5'd7};
    #1;
    n_checks++;
    if (rdata_m !== {32'h22, 32'h22}) begin n_fail++; $display("FAIL collide_bypass: got %h want 0000002200000022", rdata_m); end
    tick();
    we_m = 2'b00;
    #1;
    n_checks++;
    if (conf_m !== 1'b1) begin n_fail++; $display("FAIL collide_flag: got %b want 1", conf_m); end
    n_checks++;
    if (rdata_m[31:0] !== 32'h22) begin n_fail++; $display("FAIL collide_stored: got %h want 00000022", rdata_m[31:0]); end
    tick();
    n_checks++;
    if (conf_m !== 1'b0) begin n_fail++; $display("FAIL collide_pulse_len: got %b want 0", conf_m); end
    // distinct addresses on both ports: both commit, no flag
    we_m = 2'b11; waddr_m = {5'd11, 5'd10}; wdata_m = {32'hB1, 32'hA0};
    tick();
    we_m = 2'b00; raddr_m = {5'd11, 5'd10};
    #1;
    n_checks++;
    if (rdata_m !== {32'hB1, 32'hA0}) begin n_fail++; $display("FAIL dual_write: got %h want 000000b1000000a0", rdata_m); end
    n_checks++;
    if (conf_m !== 1'b0) begin n_fail++; $display("FAIL dual_write_conflict: got %b want 0", conf_m); end
  endtask

  task automatic test_x0();
    we_m = 2'b11; waddr_m = {5'd0, 5'd0}; wdata_m = {32'hFFFFFFFF, 32'hFFFFFFFF};
    raddr_m = {5'd0, 5'd0};
    #1;
    n_checks++;
    if (rdata_m !== 64'h0) begin n_fail++; $display("FAIL x0_bypass: got %h want 0", rdata_m); end
    tick();
    we_m = 2'b00;
    #1;
    n_checks++;
    if (rdata_m !== 64'h0) begin n_fail++; $display("FAIL x0_stored: got %h want 0", rdata_m); end
    n_checks++;
    if (conf_m !== 1'b0) begin n_fail++; $display("FAIL x0_conflict: got %b want 0", conf_m); end
  endtask

  task automatic test_init_req();
    we_m = 2'b01; waddr_m = {5'd0, 5'd9}; wdata_m = {32'h0, 32'h55};
    tick();
    we_m = 2'b00; raddr_m = {5'd3, 5'd9};
    #1;
    n_checks++;
    if (rdata_m[31:0] !== 32'h55) begin n_fail++; $display("FAIL x9_written: got %h want 00000055", rdata_m[31:0]); end
    init_m = 1'b1;
    tick();
    init_m = 1'b0;
    n_checks++;
    if (ready_m !== 1'b0) begin n_fail++; $display("FAIL init_req_ready_low: got %b want 1'b0", ready_m); end
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 31) begin
        n_checks++;
        if (ready_m !== 1'b0) begin n_fail++; $display("FAIL reinit_edge31: got %b want 0", ready_m); end
      end
    end
    n_checks++;
    if (ready_m !== 1'b1) begin n_fail++; $display("FAIL reinit_edge32: got %b want 1", ready_m); end
    n_checks++;
    if (rdata_m !== {32'h3, 32'h9}) begin n_fail++; $display("FAIL reinit_values: got %h want 0000000300000009", rdata_m); end
  endtask

  task automatic test_reset_mid();
    // asynchronous assertion during RUN
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ready_m !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready: got %b want 0", ready_m); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ready_m !== 1'b0) begin n_fail++; $display("FAIL midinit_reset_ready: got %b want 0", ready_m); end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 16) begin
        n_checks++;
        if (ready_s !== 1'b1) begin n_fail++; $display("FAIL restart_small_16: got %b want 1", ready_s); end
      end
      if (i == 31) begin
        n_checks++;
        if (ready_m !== 1'b0) begin n_fail++; $display("FAIL restart_edge31: got %b want 0", ready_m); end
      end
    end
    n_checks++;
    if (ready_m !== 1'b1) begin n_fail++; $display("FAIL restart_edge32: got %b want 1", ready_m); end
  endtask

  task automatic test_small();
    we_s = 1'b1; waddr_s = 4'd6; wdata_s = 32'hCAFE;
    raddr_s = {4'd6, 4'd15, 4'd6};
    #1;
    n_checks++;
    if (rdata_s !== {32'hCAFE, 32'hF, 32'hCAFE}) begin n_fail++; $display("FAIL small_bypass: got %h want 0000cafe0000000f0000cafe", rdata_s); end
    tick();
    we_s = 1'b0;
    raddr_s = {4'd0, 4'd6, 4'd1};
    #1;
    n_checks++;
    if (rdata_s !== {32'h0, 32'hCAFE, 32'h1}) begin n_fail++; $display("FAIL small_stored: got %h want 000000000000cafe00000001", rdata_s); end
    n_checks++;
    if (conf_s !== 1'b0) begin n_fail++; $display("FAIL small_conflict: got %b want 0", conf_s); end
  endtask

  initial begin
    rst_n  = 1'b0;
    init_m = 1'b0; we_m = '0; waddr_m = '0; wdata_m = '0; raddr_m = '0;
    init_z = 1'b0; we_z = '0; waddr_z = '0; wdata_z = '0; raddr_z = '0;
    init_s = 1'b0; we_s = '0; waddr_s = '0; wdata_s = '0; raddr_s = '0;
    tick(); tick(); tick();
    test_reset();
    test_init_seq();
    test_write_bypass();
    test_collision();
    test_x0();
    test_init_req();
    test_reset_mid();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
